// File: rtl/enigma_pkg.sv
// Shared constants, FSM encoding and position helper for the rotor stepping controller.
package enigma_pkg;

    localparam logic [4:0] A = 5'd0;
    localparam logic [4:0] B = 5'd1;
    localparam logic [4:0] C = 5'd2;
    localparam logic [4:0] D = 5'd3;
    localparam logic [4:0] E = 5'd4;
    localparam logic [4:0] F = 5'd5;
    localparam logic [4:0] G = 5'd6;
    localparam logic [4:0] H = 5'd7;
    localparam logic [4:0] I = 5'd8;
    localparam logic [4:0] J = 5'd9;
    localparam logic [4:0] K = 5'd10;
    localparam logic [4:0] L = 5'd11;
    localparam logic [4:0] M = 5'd12;
    localparam logic [4:0] N = 5'd13;
    localparam logic [4:0] O = 5'd14;
    localparam logic [4:0] P = 5'd15;
    localparam logic [4:0] Q = 5'd16;
    localparam logic [4:0] R = 5'd17;
    localparam logic [4:0] S = 5'd18;
    localparam logic [4:0] T = 5'd19;
    localparam logic [4:0] U = 5'd20;
    localparam logic [4:0] V = 5'd21;
    localparam logic [4:0] W = 5'd22;
    localparam logic [4:0] X = 5'd23;
    localparam logic [4:0] Y = 5'd24;
    localparam logic [4:0] Z = 5'd25;

    localparam logic [4:0] LAST_POS = 5'd25;

    // Notch positions of the historical rotors I, II and III.
    localparam logic [4:0] NOTCH_I   = 5'd16;
    localparam logic [4:0] NOTCH_II  = 5'd4;
    localparam logic [4:0] NOTCH_III = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [4:0] inc_pos(input logic [4:0] p);
        return (p == LAST_POS) ? 5'd0 : p + 5'd1;
    endfunction

endpackage

// File: rtl/enigma_step_controller_if.sv
// Keypress/load handshake and rotor status bundle between requester and step controller.
// Handshake: a key is accepted on a rising clock edge where key_valid && key_ready;
// key_ready is low whenever load is high or the controller is not idle, and nothing is queued.
interface enigma_step_controller_if;
    import enigma_pkg::*;

    logic       load;
    logic [4:0] load_pos_l;
    logic [4:0] load_pos_m;
    logic [4:0] load_pos_r;
    logic       key_valid;
    logic       key_ready;
    logic [4:0] pos_l;
    logic [4:0] pos_m;
    logic [4:0] pos_r;
    logic       step_l;
    logic       step_m;
    logic       step_r;
    logic       enc_strobe;
    logic       busy;
    logic       cfg_err;
    state_t     state;

    modport master (
        output load, load_pos_l, load_pos_m, load_pos_r, key_valid,
        input  key_ready, pos_l, pos_m, pos_r, step_l, step_m, step_r,
               enc_strobe, busy, cfg_err, state
    );

    modport slave (
        input  load, load_pos_l, load_pos_m, load_pos_r, key_valid,
        output key_ready, pos_l, pos_m, pos_r, step_l, step_m, step_r,
               enc_strobe, busy, cfg_err, state
    );

endinterface

// File: rtl/enigma_step_logic.sv
// Ratchet and double-step decision for one keypress, from pre-step rotor positions.
module enigma_step_logic
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH_R = NOTCH_III,
    parameter logic [4:0] NOTCH_M = NOTCH_II
) (
    input  logic [4:0] i_pos_l,
    input  logic [4:0] i_pos_m,
    input  logic [4:0] i_pos_r,
    output logic [4:0] o_next_l,
    output logic [4:0] o_next_m,
    output logic [4:0] o_next_r,
    output logic       o_step_l,
    output logic       o_step_m,
    output logic       o_step_r
);

    always_comb begin
        o_step_r = 1'b1;
        // A middle rotor sitting on its notch drags itself and the left rotor along.
        o_step_l = (i_pos_m == NOTCH_M);
        o_step_m = (i_pos_r == NOTCH_R) || (i_pos_m == NOTCH_M);
        o_next_r = inc_pos(i_pos_r);
        o_next_m = o_step_m ? inc_pos(i_pos_m) : i_pos_m;
        o_next_l = o_step_l ? inc_pos(i_pos_l) : i_pos_l;
    end

endmodule

// File: rtl/enigma_step_controller.sv
// Owns the three rotor positions: steps them per keypress, waits for the scrambler to settle, strobes.
module enigma_step_controller
    import enigma_pkg::*;
#(
    parameter logic [4:0]  NOTCH_R       = NOTCH_III,
    parameter logic [4:0]  NOTCH_M       = NOTCH_II,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    enigma_step_controller_if.slave    bus
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;

    logic [4:0] r_pos_l;
    logic [4:0] r_pos_m;
    logic [4:0] r_pos_r;
    logic       r_step_l;
    logic       r_step_m;
    logic       r_step_r;
    logic       r_cfg_err;

    logic       w_key_ready;
    logic       w_accept;
    logic       w_load_ok;
    logic [4:0] w_next_l;
    logic [4:0] w_next_m;
    logic [4:0] w_next_r;
    logic       w_step_l;
    logic       w_step_m;
    logic       w_step_r;

    assign w_key_ready = (r_state == ST_IDLE) && !bus.load;
    assign w_accept    = bus.key_valid && w_key_ready;
    assign w_load_ok   = (bus.load_pos_l <= LAST_POS) &&
                         (bus.load_pos_m <= LAST_POS) &&
                         (bus.load_pos_r <= LAST_POS);

    enigma_step_logic #(
        .NOTCH_R (NOTCH_R),
        .NOTCH_M (NOTCH_M)
    ) u_step_logic (
        .i_pos_l  (r_pos_l),
        .i_pos_m  (r_pos_m),
        .i_pos_r  (r_pos_r),
        .o_next_l (w_next_l),
        .o_next_m (w_next_m),
        .o_next_r (w_next_r),
        .o_step_l (w_step_l),
        .o_step_m (w_step_m),
        .o_step_r (w_step_r)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (bus.load) begin
            // Any load, good or bad, aborts the keypress in flight.
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_next = ST_SETTLE;
                        w_cnt_next   = CNT_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pos_l   <= 5'd0;
            r_pos_m   <= 5'd0;
            r_pos_r   <= 5'd0;
            r_step_l  <= 1'b0;
            r_step_m  <= 1'b0;
            r_step_r  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_step_l <= 1'b0;
            r_step_m <= 1'b0;
            r_step_r <= 1'b0;
            if (bus.load) begin
                if (w_load_ok) begin
                    r_pos_l   <= bus.load_pos_l;
                    r_pos_m   <= bus.load_pos_m;
                    r_pos_r   <= bus.load_pos_r;
                    r_cfg_err <= 1'b0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if (w_accept) begin
                r_pos_l  <= w_next_l;
                r_pos_m  <= w_next_m;
                r_pos_r  <= w_next_r;
                r_step_l <= w_step_l;
                r_step_m <= w_step_m;
                r_step_r <= w_step_r;
            end
        end
    end

    assign bus.key_ready  = w_key_ready;
    assign bus.pos_l      = r_pos_l;
    assign bus.pos_m      = r_pos_m;
    assign bus.pos_r      = r_pos_r;
    assign bus.step_l     = r_step_l;
    assign bus.step_m     = r_step_m;
    assign bus.step_r     = r_step_r;
    // A load arriving in the DONE cycle suppresses the strobe it is aborting.
    assign bus.enc_strobe = (r_state == ST_DONE) && !bus.load;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.cfg_err    = r_cfg_err;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_enigma_step_controller.sv
// Scoreboard bench for the rotor stepping controller with an arithmetic Enigma stepping model.
module tb_enigma_step_controller;
    import enigma_pkg::*;

    localparam int SETTLE = 2;
    localparam int MOD_NOTCH_R = 21;
    localparam int MOD_NOTCH_M = 4;

    logic clock;
    logic resetn;
    int   cyc;

    enigma_step_controller_if bus ();

    enigma_step_controller #(
        .NOTCH_R       (5'd21),
        .NOTCH_M       (5'd4),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];   // {pos_l, pos_m, pos_r, step_l, step_m, step_r}
    int          exp_t[$];   // cycle in which the step pulse must be visible
    int          exp_s[$];   // cycle in which enc_strobe must be visible
    int          n_checks;
    int          n_pass;

    // reference model state
    int ml, mm, mr;
    bit merr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (bus.step_l || bus.step_m || bus.step_r) begin
                check("step_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("step_data", {bus.pos_l, bus.pos_m, bus.pos_r, bus.step_l, bus.step_m, bus.step_r},
                          exp_q.pop_front());
                    check("step_cycle", cyc, exp_t.pop_front());
                    check("busy_while_stepping", bus.busy, 1);
                end
            end
            if (bus.enc_strobe) begin
                check("strobe_expected", exp_s.size() > 0, 1);
                if (exp_s.size() > 0) check("strobe_cycle", cyc, exp_s.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_key();
        bit dl, dm;
        dl = (mm == MOD_NOTCH_M);
        dm = (mr == MOD_NOTCH_R) || dl;
        mr = (mr + 1) % 26;
        if (dm) mm = (mm + 1) % 26;
        if (dl) ml = (ml + 1) % 26;
        exp_q.push_back({5'(ml), 5'(mm), 5'(mr), dl, dm, 1'b1});
    endtask

    // Waits for key_ready at a negedge, presents one key, returns at the negedge after acceptance.
    task automatic accept_key(input bit exp_strobe, output int c);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.key_ready && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (!bus.key_ready) begin
            check("key_ready_timeout", bus.key_ready, 1);
            c = -100;
            return;
        end
        bus.key_valid = 1'b1;
        c = cyc;
        model_key();
        exp_t.push_back(c + 1);
        if (exp_strobe) exp_s.push_back(c + SETTLE + 1);
        @(negedge clock);
        bus.key_valid = 1'b0;
    endtask

    // Runs out the busy window, optionally toggling key_valid, and checks key_ready returns on time.
    task automatic finish_key(input int c, input bit pulse);
        while (cyc < c + SETTLE + 2) begin
            bus.key_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
        end
        bus.key_valid = 1'b0;
        #1;
        check("ready_latency", bus.key_ready, 1);
        check("idle_after_key", bus.busy, 0);
    endtask

    task automatic press(input bit pulse);
        int c;
        accept_key(1'b1, c);
        finish_key(c, pulse);
    endtask

    // Drives load for one edge starting now (caller is between a negedge and the next posedge).
    task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
        bus.load       = 1'b1;
        bus.load_pos_l = l;
        bus.load_pos_m = m;
        bus.load_pos_r = r;
        #1;
        check("ready_during_load", bus.key_ready, 0);
        @(negedge clock);
        bus.load = 1'b0;
        if (l <= 25 && m <= 25 && r <= 25) begin
            ml = l; mm = m; mr = r; merr = 1'b0;
        end else begin
            merr = 1'b1;
        end
        check("load_pos", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'(ml), 5'(mm), 5'(mr)});
        check("load_cfg_err", bus.cfg_err, merr);
        check("load_idle", bus.busy, 0);
    endtask

    function automatic logic [4:0] rand_pos_maybe_bad();
        return ($urandom_range(0, 5) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int c;
        n_checks = 0;
        n_pass   = 0;
        ml = 0; mm = 0; mr = 0; merr = 1'b0;
        resetn         = 1'b0;
        bus.load       = 1'b0;
        bus.load_pos_l = 5'd0;
        bus.load_pos_m = 5'd0;
        bus.load_pos_r = 5'd0;
        bus.key_valid  = 1'b1;

        // reset state with key_valid held high
        repeat (3) @(negedge clock);
        #1;
        check("rst_pos", {bus.pos_l, bus.pos_m, bus.pos_r}, 15'd0);
        check("rst_key_ready", bus.key_ready, 1);
        check("rst_steps", {bus.step_l, bus.step_m, bus.step_r}, 3'b000);
        check("rst_strobe", bus.enc_strobe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        bus.key_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        // first key after reset
        press(1'b0);
        check("t1_pos", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd0, 5'd0, 5'd1});

        // ratchet and double step from ADU
        do_load(A, D, U);
        press(1'b0);
        check("t2_k1", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd0, 5'd3, 5'd21});
        press(1'b0);
        check("t2_k2", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd0, 5'd4, 5'd22});
        press(1'b0);
        check("t2_k3", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd1, 5'd5, 5'd23});

        // wrap-around
        do_load(Z, Z, Z);
        press(1'b0);
        check("t3_wrap_r", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd25, 5'd25, 5'd0});
        do_load(A, E, Z);
        press(1'b0);
        check("t3_double", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd1, 5'd5, 5'd0});

        // key_valid pulsing while busy must not add steps
        press(1'b1);
        press(1'b1);

        // abort during SETTLE, then a bad load, then a good load
        accept_key(1'b0, c);
        do_load(5'd1, 5'd2, 5'd3);
        check("t5_abort_pos", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd1, 5'd2, 5'd3});
        repeat (4) @(negedge clock);
        #1;
        do_load(5'd0, 5'd26, 5'd0);
        check("t5_bad_err", bus.cfg_err, 1);
        check("t5_bad_pos", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd1, 5'd2, 5'd3});
        do_load(5'd7, 5'd8, 5'd9);
        check("t5_err_clear", bus.cfg_err, 0);

        // key_valid together with load: load wins, no step
        bus.key_valid = 1'b1;
        do_load(5'd10, 5'd11, 5'd12);
        bus.key_valid = 1'b0;
        check("t6_load_wins", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'd10, 5'd11, 5'd12});

        // asynchronous reset in the middle of SETTLE
        accept_key(1'b0, c);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_async_pos", {bus.pos_l, bus.pos_m, bus.pos_r}, 15'd0);
        check("t6_async_step", {bus.step_l, bus.step_m, bus.step_r}, 3'b000);
        check("t6_async_busy", bus.busy, 0);
        ml = 0; mm = 0; mr = 0; merr = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        // randomized keys and loads
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clock);
                do_load(rand_pos_maybe_bad(), rand_pos_maybe_bad(), rand_pos_maybe_bad());
            end else if ($urandom_range(0, 5) == 0) begin
                // land close to the notches to exercise carries
                @(negedge clock);
                do_load(5'($urandom_range(0, 25)), 5'($urandom_range(3, 5)), 5'($urandom_range(19, 25)));
            end else begin
                press(1'($urandom_range(0, 1)));
                check("rnd_pos", {bus.pos_l, bus.pos_m, bus.pos_r}, {5'(ml), 5'(mm), 5'(mr)});
            end
        end

        repeat (6) @(negedge clock);
        check("step_queue_drained", exp_q.size(), 0);
        check("strobe_queue_drained", exp_s.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
